// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Holds the PC, fetches one instruction at a time from instruction memory
// over a req/ready handshake, presents it to decode/execute and computes the
// next PC from the decoder's jump/jump_reg/branch outputs and the ALU zero flag.
// Single-issue, no delay slot.
//
// Optional feature macro: ALIGN_CHECK_EN
//   defined   : a jr target with bits[1:0] != 0 sets a sticky align_err and
//               parks the unit in ERROR until reset (pc is not updated).
//   undefined : redirect targets have bits[1:0] forced to 2'b00, align_err = 0.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   imem_req/imem_addr   fetch request and byte address (= pc)
//   imem_ready/rdata     memory accept + returned instruction word
//   instr/instr_valid    captured instruction for decode/execute
//   stall                downstream hold request
//   pc/pc_plus4          current instruction address and its link address
//   jump/jump_reg/branch decoder control for the current instruction
//   alu_zero             ALU zero flag for beq
//   reg_target           rs value for jr
//   align_err            sticky misaligned-target flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned          IMEM_AW  = 32,
    parameter logic [IMEM_AW-1:0]   RESET_PC = IMEM_AW'(32'h0000_0000)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic               instr_valid,
    input  logic               stall,
    output logic [IMEM_AW-1:0] pc,
    output logic [IMEM_AW-1:0] pc_plus4,
    input  logic               jump,
    input  logic               jump_reg,
    input  logic               branch,
    input  logic               alu_zero,
    input  logic [31:0]        reg_target,
    output logic               align_err
);

    localparam int unsigned        INSTR_W     = 32;
    localparam logic [IMEM_AW-1:0] INSTR_BYTES = IMEM_AW'(4);

`ifdef ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_ERROR = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_e;
`endif

    state_e               state_q;
    logic [IMEM_AW-1:0]   pc_q;
    logic [IMEM_AW-1:0]   pc_plus4_q;
    logic [INSTR_W-1:0]   instr_q;
    logic                 imem_req_q;
    logic                 instr_valid_q;
    logic                 align_err_q;

    logic [IMEM_AW-1:0]   next_pc_d;
    logic                 misalign_d;
    logic [31:0]          pc4_32;
    logic [31:0]          jump_tgt32;
    logic signed [31:0]   br_off32;
    logic [IMEM_AW-1:0]   jr_tgt;

    // Next-PC selection: jr > j/jal > taken beq > fall-through
    always_comb begin
        next_pc_d  = pc_plus4_q;
        misalign_d = 1'b0;
        pc4_32     = 32'(pc_plus4_q);
        jump_tgt32 = {pc4_32[31:28], instr_q[25:0], 2'b00};
        br_off32   = $signed({{14{instr_q[15]}}, instr_q[15:0], 2'b00});
        jr_tgt     = IMEM_AW'(reg_target);

        if (jump_reg) begin
`ifdef ALIGN_CHECK_EN
            next_pc_d  = jr_tgt;
            misalign_d = |reg_target[1:0];
`else
            // Low bits dropped: targets are always word aligned
            next_pc_d  = jr_tgt & ~IMEM_AW'(3);
`endif
        end else if (jump) begin
            next_pc_d = IMEM_AW'(jump_tgt32);
        end else if (branch && alu_zero) begin
            next_pc_d = pc_plus4_q + IMEM_AW'(br_off32);
        end
    end

    // Fetch FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + INSTR_BYTES;
            instr_q       <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_FETCH;
                    imem_req_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr_q       <= imem_rdata;
                        state_q       <= ST_VALID;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (!stall) begin
`ifdef ALIGN_CHECK_EN
                        if (misalign_d) begin
                            state_q       <= ST_ERROR;
                            align_err_q   <= 1'b1;
                            instr_valid_q <= 1'b0;
                            imem_req_q    <= 1'b0;
                        end else begin
                            pc_q          <= next_pc_d;
                            pc_plus4_q    <= next_pc_d + INSTR_BYTES;
                            state_q       <= ST_FETCH;
                            imem_req_q    <= 1'b1;
                            instr_valid_q <= 1'b0;
                        end
`else
                        pc_q          <= next_pc_d;
                        pc_plus4_q    <= next_pc_d + INSTR_BYTES;
                        state_q       <= ST_FETCH;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
`endif
                    end
                end
`ifdef ALIGN_CHECK_EN
                ST_ERROR: begin
                    // Parked until reset
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
`endif
                default: begin
                    state_q       <= ST_IDLE;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_q;
`ifdef ALIGN_CHECK_EN
    assign align_err   = align_err_q;
`else
    assign align_err   = 1'b0;
    logic unused_align;
    assign unused_align = align_err_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed self-checking bench for instr_fetch_unit: reset values, zero-wait
// and wait-state fetches, stall hold, beq taken/not-taken, jal, jr priority,
// address wrap, misaligned jr and asynchronous reset during a fetch.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        jump;
    logic        jump_reg;
    logic        branch;
    logic        alu_zero;
    logic [31:0] reg_target;
    logic        align_err;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .reg_target  (reg_target),
        .align_err   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects the unit in FETCH at addr; holds ready low for waits cycles
    task automatic fetch_word(input logic [31:0] addr, input logic [31:0] word, input int waits);
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            step();
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, addr);
            check("wait_valid", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        check("valid", 32'(instr_valid), 32'd1);
        check("instr", instr, word);
        check("valid_req", 32'(imem_req), 32'd0);
        check("valid_pc", pc, addr);
    endtask

    // Drives decoder control for one VALID cycle with stall=0
    task automatic issue(input logic j, input logic jr, input logic br, input logic z,
                         input logic [31:0] tgt, input logic [31:0] exp_pc);
        jump       = j;
        jump_reg   = jr;
        branch     = br;
        alu_zero   = z;
        reg_target = tgt;
        step();
        jump       = 1'b0;
        jump_reg   = 1'b0;
        branch     = 1'b0;
        alu_zero   = 1'b0;
        reg_target = 32'h0;
        check("next_pc", pc, exp_pc);
        check("next_pc_plus4", pc_plus4, exp_pc + 32'd4);
        check("next_valid", 32'(instr_valid), 32'd0);
        check("next_req", 32'(imem_req), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        branch     = 1'b0;
        alu_zero   = 1'b0;
        reg_target = 32'h0;

        // Reset values
        #12;
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_align", 32'(align_err), 32'd0);
        rst_n = 1'b1;

        // IDLE -> FETCH, then zero-wait fetches 0 -> 4 -> 8
        step();
        fetch_word(32'h0, 32'h2009_0005, 0);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        fetch_word(32'h4, 32'h0000_0000, 0);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8);

        // Three wait states, then two stall cycles with control ignored
        fetch_word(32'h8, 32'h0000_0020, 3);
        stall      = 1'b1;
        jump_reg   = 1'b1;
        reg_target = 32'h0000_4444;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_instr", instr, 32'h0000_0020);
            check("stall_pc", pc, 32'h8);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;

        // jr wins over simultaneous jump
        issue(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h10);

        // beq at 0x10, imm -4: taken -> 0x04
        fetch_word(32'h10, 32'h1000_FFFC, 0);
        issue(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h04);
        fetch_word(32'h4, 32'h0000_0000, 0);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h10);
        // not taken -> 0x14
        fetch_word(32'h10, 32'h1000_FFFC, 0);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h14);

        // Address wrap at the top of the space
        fetch_word(32'h14, 32'h0000_0000, 0);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch_word(32'hFFFF_FFFC, 32'h0000_0000, 0);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // jal at 0x4000_0000, target field 0x40 -> 0x4000_0100
        fetch_word(32'h0, 32'h0000_0000, 0);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 32'h4000_0000);
        fetch_word(32'h4000_0000, 32'h0C00_0040, 0);
        check("jal_link", pc_plus4, 32'h4000_0004);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h4000_0100);

        // Misaligned jr target
        fetch_word(32'h4000_0100, 32'h0000_0008, 0);
        jump       = 1'b1;
        jump_reg   = 1'b1;
        reg_target = 32'h0000_0202;
        step();
        jump       = 1'b0;
        jump_reg   = 1'b0;
        reg_target = 32'h0;
`ifdef ALIGN_CHECK_EN
        check("err_align", 32'(align_err), 32'd1);
        check("err_req", 32'(imem_req), 32'd0);
        check("err_valid", 32'(instr_valid), 32'd0);
        check("err_pc", pc, 32'h4000_0100);
        step();
        check("err_sticky", 32'(align_err), 32'd1);
        check("err_req_hold", 32'(imem_req), 32'd0);
        // Return to a FETCH with a non-zero instruction held
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        fetch_word(32'h0, 32'h0000_0008, 0);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
`else
        check("jr_masked_pc", pc, 32'h0000_0200);
        check("jr_masked_align", 32'(align_err), 32'd0);
        check("jr_masked_req", 32'(imem_req), 32'd1);
`endif

        // Asynchronous reset mid-FETCH with ready high
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_pc_plus4", pc_plus4, 32'h4);
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_instr", instr, 32'h0);
        check("arst_align", 32'(align_err), 32'd0);
        step();
        check("arst_no_capture", instr, 32'h0);
        check("arst_valid_hold", 32'(instr_valid), 32'd0);
        rst_n      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        step();
        check("post_rst_instr", instr, 32'h0);
        fetch_word(32'h0, 32'h1234_5678, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Produces the op_code/func stream that the instruction decoder consumes, and is the consumer of the decoder's Jump/JumpReg/Branch outputs.
- Holds the PC and issues requests to instruction memory through a req/ready handshake.
- Presents one instruction at a time and computes the next PC from the decoded control and the ALU zero flag.
- Single-issue, no delay slot; sits between instruction memory and the control unit/datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 32, width of the instruction memory byte address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  IMEM_AW  byte address of the fetch; equals pc.
- imem_ready  in  1  memory accepts the request and returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- instr  out  32  captured instruction; op_code=instr[31:26], func=instr[5:0].
- instr_valid  out  1  instr is valid for decode/execute.
- stall  in  1  downstream not ready; hold the current instruction.
- pc  out  IMEM_AW  address of the current instruction.
- pc_plus4  out  IMEM_AW  pc+4, used as the link address for jal.
- jump  in  1  from decoder: J-format jump (j/jal).
- jump_reg  in  1  from decoder: jr.
- branch  in  1  from decoder: beq.
- alu_zero  in  1  ALU zero flag for the current instruction.
- reg_target  in  32  rs value for jr.
- align_err  out  1  sticky misaligned-target flag (ALIGN_CHECK_EN only; tied 0 otherwise).

Behaviour:
Reset (asynchronous, rst_n=0), effective immediately:
- pc=RESET_PC, state=IDLE.
- imem_req=0, instr_valid=0, instr=32'h0, align_err=0.
- An in-flight fetch is abandoned; the imem_rdata of that fetch is never captured.

State machine:
- IDLE: one cycle after reset release, imem_req=0 -> FETCH.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ready.
  - On an edge with imem_ready=1: instr<=imem_rdata -> VALID.
  - Zero-wait memory (ready in the first FETCH cycle) is legal.
- VALID: instr_valid=1, imem_req=0.
  - stall=1: hold instr, pc and instr_valid.
  - stall=0: pc<=next_pc -> FETCH.
- ERROR (ALIGN_CHECK_EN only): imem_req=0, instr_valid=0; exited only by reset.

Next-PC priority, decoder inputs sampled in VALID with stall=0:
- jump_reg=1 -> reg_target.
- else jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}.
- else branch=1 and alu_zero=1 -> pc_plus4 + (sign_extend(instr[15:0]) << 2).
- else -> pc_plus4.
- Inputs are ignored outside VALID, or in VALID while stall=1.

Arithmetic and boundary rules:
- All adds are modulo 2^IMEM_AW: pc 32'hFFFF_FFFC + 4 wraps to 32'h0.
- Branch with alu_zero=0 falls through to pc_plus4.
- Simultaneous jump and jump_reg: jump_reg wins.
- Latency: minimum 2 cycles per instruction (FETCH with zero-wait, then VALID), plus memory wait cycles and stall cycles.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined:
  - A redirect target with bits[1:0]!=0 (only jr can produce one) sets align_err=1 and enters ERROR; the pc is not updated.
- Undefined:
  - Target bits[1:0] are forced to 2'b00, no error state exists, and align_err is tied 0.

Test Plan:
- Reset release, zero-wait memory returning 32'h2009_0005 at pc=0 -> imem_req in FETCH, instr_valid in the next cycle, pc advances 0 -> 4 -> 8.
- imem_ready delayed 3 cycles, then stall held 2 cycles in VALID -> imem_addr stable throughout the wait; instr and pc unchanged throughout the stall.
- beq at pc=0x10, imm=16'hFFFC: alu_zero=1 -> next pc 0x04; alu_zero=0 -> next pc 0x14.
- jal at pc=0x4000_0000 with target field 26'h000_0040 -> next pc 0x4000_0100, pc_plus4=0x4000_0004.
- jr with jump=1 also asserted and reg_target=0x0000_0200 -> next pc 0x200. With ALIGN_CHECK_EN and reg_target=0x202 -> align_err=1, ERROR, imem_req=0.
- rst_n pulsed low mid-FETCH while imem_ready=1 -> outputs reset asynchronously, pc=RESET_PC, the returned data is not captured.
